// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button sync/debounce, mode FSM,
// 1/100 s count-enable prescaler, counter clear and lap hold.
module stopwatch_ctrl #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       fStart,
  input  logic       fStop,
  input  logic       fLap,
  output logic       oCntEn,
  output logic       oCntClr,
  output logic       oDispHold,
  output logic [1:0] oState
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [PW-1:0] PSC_MAX = PW'(DIV - 1);
  localparam logic [DW-1:0] DB_MAX  = DW'(DB_CYCLES - 1);

  localparam int B_STOP  = 0;
  localparam int B_START = 1;
  localparam int B_LAP   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_e;

  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    acc_q, acc_d;
  logic [2:0]    arm_q, arm_d;
  logic [2:0]    press_q, press_d;
  logic [DW-1:0] dbc_q [3];
  logic [DW-1:0] dbc_d [3];

  assign raw = {fLap, fStart, fStop};

  // Until armed, a button is treated as held: it must be seen
  // stable high for DB_CYCLES before any press is accepted.
  always_comb begin
    acc_d   = acc_q;
    arm_d   = arm_q;
    press_d = '0;
    for (int i = 0; i < 3; i++) begin
      dbc_d[i] = '0;
      if (sync2_q[i] != (arm_q[i] & acc_q[i])) begin
        if (dbc_q[i] == DB_MAX) begin
          if (!arm_q[i]) begin
            arm_d[i] = 1'b1;
          end else begin
            acc_d[i]   = sync2_q[i];
            press_d[i] = ~sync2_q[i];
          end
        end else begin
          dbc_d[i] = dbc_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      acc_q   <= '1;
      arm_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < 3; i++) dbc_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      arm_q   <= arm_d;
      press_q <= press_d;
      for (int i = 0; i < 3; i++) dbc_q[i] <= dbc_d[i];
    end
  end

  logic ev_stop, ev_start, ev_lap;

  assign ev_stop  = press_q[B_STOP];
  assign ev_start = press_q[B_START] & ~ev_stop;
  assign ev_lap   = press_q[B_LAP] & ~press_q[B_STOP]
                  & ~press_q[B_START];

  state_e        state_q;
  logic [PW-1:0] psc_q;
  logic          cnt_en_q, cnt_clr_q, hold_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      psc_q     <= '0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ev_start) begin
            state_q <= RUN;
            psc_q   <= '0;
          end
        end
        RUN, LAP: begin
          if (ev_stop) begin
            state_q <= PAUSE;
            hold_q  <= 1'b0;
          end else begin
            if (ev_lap) begin
              state_q <= (state_q == RUN) ? LAP : RUN;
              hold_q  <= (state_q == RUN);
            end
            if (psc_q == PSC_MAX) begin
              psc_q    <= '0;
              cnt_en_q <= 1'b1;
            end else begin
              psc_q <= psc_q + 1'b1;
            end
          end
        end
        PAUSE: begin
          if (ev_stop) begin
            state_q   <= IDLE;
            psc_q     <= '0;
            cnt_clr_q <= 1'b1;
          end else if (ev_start) begin
            state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oCntEn    = cnt_en_q;
  assign oCntClr   = cnt_clr_q;
  assign oDispHold = hold_q;
  assign oState    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10, DB_CYCLES=4.
module tb_stopwatch_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       fStart = 1'b1;
  logic       fStop = 1'b1;
  logic       fLap = 1'b1;
  logic       oCntEn, oCntClr, oDispHold;
  logic [1:0] oState;

  int n_chk  = 0;
  int n_pass = 0;
  int n, c;

  stopwatch_ctrl #(
    .CLK_HZ   (1000),
    .TICK_HZ  (100),
    .DB_CYCLES(4)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .fStart   (fStart),
    .fStop    (fStop),
    .fLap     (fLap),
    .oCntEn   (oCntEn),
    .oCntClr  (oCntClr),
    .oDispHold(oDispHold),
    .oState   (oState)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // cycles until next oCntEn pulse, 0 if none within 40
  task automatic wait_en(output int r);
    r = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (oCntEn === 1'b1) begin
        r = i;
        break;
      end
    end
  endtask

  task automatic count_en(input int len, output int r);
    r = 0;
    for (int i = 0; i < len; i++) begin
      tick();
      if (oCntEn === 1'b1) r++;
    end
  endtask

  initial begin
    tick(2);
    chk("rst_state", 32'(oState), 0);
    chk("rst_en", 32'(oCntEn), 0);
    chk("rst_clr", 32'(oCntClr), 0);
    chk("rst_hold", 32'(oDispHold), 0);
    Rst = 1'b1;
    tick(8);

    // start press: state changes 7 cycles after the falling edge
    fStart = 1'b0;
    tick(6);
    chk("s1_pre", 32'(oState), 0);
    tick();
    chk("s1_run", 32'(oState), 1);
    wait_en(n);
    chk("s1_first_tick", n, 10);
    wait_en(n);
    chk("s1_period", n, 10);
    chk("s1_held", 32'(oState), 1);
    fStart = 1'b1;

    // short stop glitch
    fStop = 1'b0;
    tick(2);
    fStop = 1'b1;
    wait_en(n);
    chk("s2_tick", n, 8);
    chk("s2_state", 32'(oState), 1);
    wait_en(n);
    chk("s2_period", n, 10);

    // lap in / lap out
    fLap = 1'b0;
    tick(7);
    chk("s3_lap", 32'(oState), 3);
    chk("s3_hold", 32'(oDispHold), 1);
    fLap = 1'b1;
    wait_en(n);
    chk("s3_tick", n, 3);
    wait_en(n);
    chk("s3_period", n, 10);
    chk("s3_still_lap", 32'(oState), 3);
    fLap = 1'b0;
    tick(7);
    chk("s3_run", 32'(oState), 1);
    chk("s3_unhold", 32'(oDispHold), 0);
    fLap = 1'b1;
    wait_en(n);
    chk("s3_tick2", n, 3);

    // pause at prescaler 4, resume
    tick(8);
    fStop = 1'b0;
    tick(2);
    chk("s4_last_tick", 32'(oCntEn), 1);
    tick(5);
    chk("s4_pause", 32'(oState), 2);
    fStop = 1'b1;
    count_en(20, c);
    chk("s4_no_tick", c, 0);
    fStart = 1'b0;
    tick(7);
    chk("s4_resume", 32'(oState), 1);
    fStart = 1'b1;
    wait_en(n);
    chk("s4_resume_tick", n, 6);

    // stop twice -> clear
    fStop = 1'b0;
    tick(7);
    chk("s4_pause2", 32'(oState), 2);
    fStop = 1'b1;
    tick(8);
    fStop = 1'b0;
    tick(6);
    chk("s4_pre_clr", 32'(oCntClr), 0);
    tick();
    chk("s4_idle", 32'(oState), 0);
    chk("s4_clr", 32'(oCntClr), 1);
    chk("s4_clr_no_en", 32'(oCntEn), 0);
    tick();
    chk("s4_clr_1cyc", 32'(oCntClr), 0);
    fStop = 1'b1;
    tick(8);

    // start and stop together: stop wins
    fStart = 1'b0;
    tick(7);
    chk("s5_run", 32'(oState), 1);
    fStart = 1'b1;
    tick(8);
    fStart = 1'b0;
    fStop  = 1'b0;
    tick(7);
    chk("s5_stop_wins", 32'(oState), 2);
    fStart = 1'b1;
    fStop  = 1'b1;
    tick(20);
    chk("s5_no_start", 32'(oState), 2);

    // reset during lap with buttons held
    fStart = 1'b0;
    tick(7);
    chk("s6_run", 32'(oState), 1);
    fStart = 1'b1;
    tick(8);
    fLap = 1'b0;
    tick(7);
    chk("s6_lap", 32'(oState), 3);
    chk("s6_hold", 32'(oDispHold), 1);
    fStart = 1'b0;
    tick(10);
    chk("s6_start_ign", 32'(oState), 3);
    Rst = 1'b0;
    #1;
    chk("s6_rst_state", 32'(oState), 0);
    chk("s6_rst_hold", 32'(oDispHold), 0);
    chk("s6_rst_en", 32'(oCntEn), 0);
    chk("s6_rst_clr", 32'(oCntClr), 0);
    tick(2);
    Rst = 1'b1;
    tick(20);
    chk("s6_held_start", 32'(oState), 0);
    fStart = 1'b1;
    tick(6);
    fStart = 1'b0;
    tick(7);
    chk("s6_repress", 32'(oState), 1);
    fStart = 1'b1;
    tick(10);
    chk("s6_held_lap", 32'(oState), 1);
    fLap = 1'b1;
    tick(6);
    fLap = 1'b0;
    tick(7);
    chk("s6_lap_again", 32'(oState), 3);
    fLap = 1'b1;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the stopwatch datapath. Takes the three raw active-low pushbuttons (start, stop, lap), synchronizes and debounces them, and runs the stopwatch mode FSM. Generates the 1/100 s count-enable tick, the counter clear, and the display-hold (lap) strobe. It sits between the board buttons and the BCD counter/7-segment datapath, and replaces ad-hoc button handling in the counter.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz
TICK_HZ, 100, count-enable tick rate in Hz; DIV = CLK_HZ/TICK_HZ, which must be an integer and at least 2
DB_CYCLES, 1_000_000, consecutive stable cycles required to accept a button level (20 ms at 50 MHz)

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous active-low reset
fStart  input  1  raw start button, active-low, asynchronous to Clk
fStop  input  1  raw stop button, active-low, asynchronous to Clk
fLap  input  1  raw lap button, active-low, asynchronous to Clk
oCntEn  output  1  one-cycle pulse: advance the counter by 0.01 s
oCntClr  output  1  one-cycle pulse: clear the counter to 00.00
oDispHold  output  1  level: display shows the frozen lap value
oState  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP

Behaviour:
- Reset (Rst=0, async): state IDLE; oCntEn=0, oCntClr=0, oDispHold=0, oState=00; prescaler=0; all debouncers in the released state with counters at 0; sync flops at 1.
- Per-button input path: 2-flop synchronizer, then debouncer.
- Debouncer: counter increments while the synced level differs from the accepted level and resets to 0 when it matches. When the counter reaches DB_CYCLES-1, the accepted level flips.
- A high-to-low flip of the accepted level emits one press pulse. Exactly one pulse per press; holding the button produces no repeats.
- Glitches shorter than DB_CYCLES produce no event.
- Latency: press pulse is asserted DB_CYCLES+2 cycles after the raw falling edge. oState changes on the following clock edge.
- Same-cycle event priority: stop > start > lap. Only the highest-priority event is acted on; the others are dropped.
- FSM transitions:
  - IDLE: start -> RUN and prescaler cleared to 0. stop and lap are ignored.
  - RUN: stop -> PAUSE. lap -> LAP and oDispHold=1. start is ignored.
  - LAP: lap -> RUN and oDispHold=0; counting continues throughout. stop -> PAUSE and oDispHold=0. start is ignored.
  - PAUSE: start -> RUN; the prescaler resumes from its held value. stop -> IDLE, with oCntClr pulsed for exactly 1 cycle (registered, coincident with the state change) and the prescaler cleared. lap is ignored.
- Prescaler: counts 0..DIV-1 only in RUN or LAP. In IDLE and PAUSE it holds its value.
- oCntEn is registered. It is 1 for exactly one cycle on the cycle after the prescaler is at DIV-1 in RUN/LAP; the prescaler wraps to 0 at that point.
- In a steady RUN, tick period is exactly DIV cycles. The first tick after IDLE->RUN arrives DIV cycles after the state change.
- A transition to PAUSE on the same edge the prescaler is at DIV-1 suppresses that tick; the prescaler holds at DIV-1. On resume, the tick fires one cycle later.
- oCntEn and oCntClr are never asserted in the same cycle.
- Reset mid-operation: immediate return to reset values. Buttons still held low during and after reset must first be released (stable high for DB_CYCLES) before they can generate a new press.

Test Plan:
All scenarios use CLK_HZ=1000, TICK_HZ=100 (DIV=10) and DB_CYCLES=4.
1. Reset, then fStart low for 10 cycles -> oState 00->01 at DB_CYCLES+3 = 7 cycles after the falling edge. oCntEn pulses every 10 cycles, the first 10 cycles after entering RUN. No repeat while fStart stays low.
2. 2-cycle low glitch on fStop while in RUN -> no state change. oCntEn period stays at 10 cycles.
3. RUN, then lap press -> oState=11, oDispHold=1, oCntEn continues every 10 cycles. Second lap press -> oState=01, oDispHold=0.
4. RUN, stop press at prescaler=4 -> PAUSE, no oCntEn. Start press -> RUN; the next oCntEn arrives 6 cycles after re-entry. Stop twice -> IDLE with a single 1-cycle oCntClr.
5. fStart and fStop driven low on the same cycle while in RUN -> oState=10 (stop wins); no start effect later because the press pulse was consumed.
6. Assert Rst during LAP while fLap is held low -> all outputs 0 and oState=00 immediately. After deassertion, no lap or start event until the button is released for 4 cycles and pressed again.
